// File: rtl/ks_memory_responder.sv
// ks_memory_responder: 32 x 16-bit boot-loadable memory answering datapath
// requests after WAIT_CYCLES wait states (legal 0..7).
// Optional feature: define KS_MEM_WRITE_PROTECT_EN to reject post-boot writes
// to addresses 0..PROTECT_TOP (legal 0..31); boot-load writes are never blocked.
module ks_memory_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int PROTECT_TOP = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ram_addr,
    input  logic [15:0] data_out,
    output logic [15:0] data_in,
    input  logic        write_enable,
    input  logic        mem_req,
    output logic        mem_ack,
    input  logic        load_valid,
    input  logic [4:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        load_done,
    output logic        boot_done,
    output logic        protect_err
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Counter value that makes WAIT last exactly WAIT_CYCLES cycles.
    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t      state;
    state_t      next_state;
    logic [2:0]  wait_cnt;
    logic [4:0]  cap_addr;
    logic [15:0] cap_data;
    logic        cap_we;
    logic [15:0] mem [32];

    logic        start;
    logic [4:0]  acc_addr;
    logic        acc_we;
    logic        write_blocked;

    // A request is accepted only in IDLE; on that edge the live inputs are the
    // access, afterwards only the captured copies are used.
    assign start    = (state == ST_IDLE) && mem_req;
    assign acc_addr = start ? ram_addr : cap_addr;
    assign acc_we   = start ? write_enable : cap_we;

    assign mem_ack   = (state == ST_RESP);
    assign boot_done = (state != ST_BOOT);

`ifdef KS_MEM_WRITE_PROTECT_EN
    localparam logic [4:0] PROTECT_LIMIT = 5'(PROTECT_TOP);
    assign write_blocked = (cap_addr <= PROTECT_LIMIT);
    assign protect_err   = (state == ST_RESP) && cap_we && write_blocked;
`else
    assign write_blocked = 1'b0;
    assign protect_err   = 1'b0;
`endif

    // State register; reset returns to BOOT and abandons any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the boot / request / wait / respond sequence.
    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            ST_BOOT: if (load_done) next_state = ST_IDLE;
            ST_IDLE: if (mem_req) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_cnt == 3'd0) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_BOOT;
        endcase
    end

    // Capture registers, wait counter and read-data register; read data is
    // loaded on entry to RESP so it is valid alongside mem_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 3'd0;
            cap_addr <= 5'd0;
            cap_data <= 16'h0000;
            cap_we   <= 1'b0;
            data_in  <= 16'h0000;
        end else begin
            if (start) begin
                cap_addr <= ram_addr;
                cap_data <= data_out;
                cap_we   <= write_enable;
                wait_cnt <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if ((next_state == ST_RESP) && (state != ST_RESP) && !acc_we) begin
                data_in <= mem[acc_addr];
            end
        end
    end

    // Storage writes: boot loads in BOOT, datapath writes at the end of RESP so
    // a reset during WAIT or RESP drops the pending write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; contents survive rst, only writes are gated by it.
        if (!rst) begin
            if ((state == ST_BOOT) && load_valid) begin
                mem[load_addr] <= load_data;
            end else if ((state == ST_RESP) && cap_we && !write_blocked) begin
                mem[cap_addr] <= cap_data;
            end
        end
    end

endmodule

// File: tb/tb_ks_memory_responder.sv
// Self-checking bench for ks_memory_responder. Four instances with
// WAIT_CYCLES = 0, 1, 3, 7 run one at a time against a per-instance
// array model of the memory and the read-data register.
module tb_ks_memory_responder;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst          = '1;
    logic [N-1:0] write_enable = '0;
    logic [N-1:0] mem_req      = '0;
    logic [N-1:0] load_valid   = '0;
    logic [N-1:0] load_done    = '0;
    logic [4:0]   ram_addr  [N];
    logic [15:0]  data_out  [N];
    logic [4:0]   load_addr [N];
    logic [15:0]  load_data [N];
    logic [15:0]  data_in   [N];
    logic [N-1:0] mem_ack;
    logic [N-1:0] boot_done;
    logic [N-1:0] protect_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_mem  [N][32];
    logic [15:0] exp_dout [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        ks_memory_responder #(
            .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 3 : 7),
            .PROTECT_TOP(15)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .ram_addr    (ram_addr[g]),
            .data_out    (data_out[g]),
            .data_in     (data_in[g]),
            .write_enable(write_enable[g]),
            .mem_req     (mem_req[g]),
            .mem_ack     (mem_ack[g]),
            .load_valid  (load_valid[g]),
            .load_addr   (load_addr[g]),
            .load_data   (load_data[g]),
            .load_done   (load_done[g]),
            .boot_done   (boot_done[g]),
            .protect_err (protect_err[g])
        );
    end

    function automatic int wc_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    function automatic logic is_protected(input logic [4:0] a);
`ifdef KS_MEM_WRITE_PROTECT_EN
        return a <= 5'd15;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(input int i);
        rst[i]          = 1'b0;
        mem_req[i]      = 1'b0;
        write_enable[i] = 1'b0;
        load_valid[i]   = 1'b0;
        load_done[i]    = 1'b0;
        ram_addr[i]     = 5'd0;
        data_out[i]     = 16'h0000;
        load_addr[i]    = 5'd0;
        load_data[i]    = 16'h0000;
    endtask

    task automatic scramble(input int i);
        mem_req[i]      = 1'($urandom);
        write_enable[i] = 1'($urandom);
        ram_addr[i]     = 5'($urandom);
        data_out[i]     = 16'($urandom);
        load_valid[i]   = 1'($urandom);
        load_done[i]    = 1'($urandom);
        load_addr[i]    = 5'($urandom);
        load_data[i]    = 16'($urandom);
    endtask

    // One access from IDLE; checks latency, ack width, protect_err, data_in.
    task automatic access(input int i, input logic we, input logic [4:0] a,
                          input logic [15:0] d, input string tag);
        int          lat;
        logic        prot;
        logic [15:0] want_dout;
        prot      = we && is_protected(a);
        want_dout = we ? exp_dout[i] : exp_mem[i][a];
        mem_req[i] = 1'b1; write_enable[i] = we; ram_addr[i] = a; data_out[i] = d;
        tick;
        lat = 1;
        while (mem_ack[i] !== 1'b1 && lat < 12) begin
            scramble(i);
            tick;
            lat++;
        end
        scramble(i);
        mem_req[i] = 1'b0;
        n_cmp++;
        if (lat != wc_of(i) + 1) begin
            n_bad++;
            $display("FAIL %s inst%0d latency: got %0d cycles, expected %0d", tag, i, lat, wc_of(i) + 1);
        end
        n_cmp++;
        if (protect_err[i] !== prot) begin
            n_bad++;
            $display("FAIL %s inst%0d protect_err in ack cycle: got %b, expected %b", tag, i, protect_err[i], prot);
        end
        n_cmp++;
        if (data_in[i] !== want_dout) begin
            n_bad++;
            $display("FAIL %s inst%0d data_in in ack cycle: got %h, expected %h", tag, i, data_in[i], want_dout);
        end
        tick;
        n_cmp++;
        if (mem_ack[i] !== 1'b0 || protect_err[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s inst%0d pulse width: mem_ack=%b protect_err=%b, expected 0 0", tag, i, mem_ack[i], protect_err[i]);
        end
        n_cmp++;
        if (data_in[i] !== want_dout) begin
            n_bad++;
            $display("FAIL %s inst%0d data_in hold: got %h, expected %h", tag, i, data_in[i], want_dout);
        end
        if (we && !prot) exp_mem[i][a] = d;
        if (!we) exp_dout[i] = want_dout;
        idle_inputs(i);
    endtask

    task automatic test_reset;
        for (int i = 0; i < N; i++) begin
            scramble(i);
            rst[i] = 1'b1;
        end
        tick;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (boot_done[i] !== 1'b0 || mem_ack[i] !== 1'b0 || protect_err[i] !== 1'b0 || data_in[i] !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset inst%0d: boot_done=%b mem_ack=%b protect_err=%b data_in=%h, expected 0 0 0 0000",
                         i, boot_done[i], mem_ack[i], protect_err[i], data_in[i]);
            end
            idle_inputs(i);
            exp_dout[i] = 16'h0000;
        end
    endtask

    // Loads all 32 words; mem_req and a write request are held high throughout
    // and must be ignored; load_done coincides with the last load.
    task automatic test_boot(input int i);
        logic [15:0] w;
        mem_req[i] = 1'b1; write_enable[i] = 1'b1; ram_addr[i] = 5'd0; data_out[i] = 16'h0000;
        for (int a = 0; a < 32; a++) begin
            w = (a == 0) ? 16'h8123 : (a == 1) ? 16'hFFFF : 16'($urandom);
            load_valid[i] = 1'b1; load_addr[i] = 5'(a); load_data[i] = w; load_done[i] = (a == 31);
            exp_mem[i][a] = w;
            tick;
            n_cmp++;
            if (mem_ack[i] !== 1'b0 || boot_done[i] !== (a == 31)) begin
                n_bad++;
                $display("FAIL boot inst%0d word %0d: mem_ack=%b boot_done=%b, expected 0 %b", i, a, mem_ack[i], boot_done[i], a == 31);
            end
        end
        idle_inputs(i);
        access(i, 1'b0, 5'd0, 16'h0, "boot_read0");
        n_cmp++;
        if (data_in[i] !== 16'h8123) begin
            n_bad++;
            $display("FAIL boot_read0 inst%0d: data_in=%h, expected 8123", i, data_in[i]);
        end
    endtask

    task automatic test_latency;
        for (int i = 0; i < N; i++) begin
            access(i, 1'b0, 5'd1, 16'h0, "latency_read1");
            n_cmp++;
            if (data_in[i] !== 16'hFFFF) begin
                n_bad++;
                $display("FAIL latency_read1 inst%0d: data_in=%h, expected ffff", i, data_in[i]);
            end
        end
    endtask

    task automatic test_protect;
        logic [15:0] want;
`ifdef KS_MEM_WRITE_PROTECT_EN
        want = 16'h8123;
`else
        want = 16'h0000;
`endif
        for (int i = 0; i < N; i++) begin
            access(i, 1'b1, 5'd0, 16'h0000, "protect_write0");
            access(i, 1'b0, 5'd0, 16'h0000, "protect_read0");
            n_cmp++;
            if (data_in[i] !== want) begin
                n_bad++;
                $display("FAIL protect_read0 inst%0d: data_in=%h, expected %h", i, data_in[i], want);
            end
        end
    endtask

    task automatic test_write_read;
        for (int i = 0; i < N; i++) begin
            access(i, 1'b1, 5'd20, 16'h1234, "wr_write20");
            access(i, 1'b0, 5'd20, 16'h0000, "wr_read20");
            n_cmp++;
            if (data_in[i] !== 16'h1234) begin
                n_bad++;
                $display("FAIL wr_read20 inst%0d: data_in=%h, expected 1234", i, data_in[i]);
            end
        end
    endtask

    // Boot strobes after boot: no ack, boot_done stays, memory untouched.
    task automatic test_ignored(input int i);
        logic [4:0] a;
        a = 5'($urandom);
        load_valid[i] = 1'b1; load_done[i] = 1'b1; load_addr[i] = a; load_data[i] = ~exp_mem[i][a];
        for (int k = 0; k < 3; k++) begin
            tick;
            n_cmp++;
            if (mem_ack[i] !== 1'b0 || boot_done[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL ignored_load inst%0d: mem_ack=%b boot_done=%b, expected 0 1", i, mem_ack[i], boot_done[i]);
            end
        end
        idle_inputs(i);
        access(i, 1'b0, a, 16'h0, "ignored_readback");
    endtask

    // Request held high: one access every WAIT_CYCLES+2 cycles.
    task automatic test_back_to_back(input int i);
        logic [4:0] a;
        int         gap;
        a = 5'($urandom);
        mem_req[i] = 1'b1; write_enable[i] = 1'b0; ram_addr[i] = a;
        gap = 0;
        do begin
            tick;
            gap++;
        end while (mem_ack[i] !== 1'b1 && gap < 12);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                gap = 0;
                mem_req[i] = 1'b1;
            end
            gap = 0;
            do begin
                tick;
                gap++;
            end while (mem_ack[i] !== 1'b1 && gap < 20);
            if (k == 2) mem_req[i] = 1'b0;
            n_cmp++;
            if (gap != wc_of(i) + 2) begin
                n_bad++;
                $display("FAIL b2b inst%0d gap %0d: got %0d cycles, expected %0d", i, k, gap, wc_of(i) + 2);
            end
            n_cmp++;
            if (data_in[i] !== exp_mem[i][a]) begin
                n_bad++;
                $display("FAIL b2b inst%0d data %0d: got %h, expected %h", i, k, data_in[i], exp_mem[i][a]);
            end
        end
        tick;
        tick;
        n_cmp++;
        if (mem_ack[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b inst%0d after release: mem_ack=%b, expected 0", i, mem_ack[i]);
        end
        exp_dout[i] = exp_mem[i][a];
        idle_inputs(i);
    endtask

    task automatic test_random(input int i);
        logic       we;
        logic [4:0] a;
        for (int k = 0; k < 24; k++) begin
            we = 1'($urandom);
            a  = 5'($urandom);
            access(i, we, a, 16'($urandom), we ? "rand_write" : "rand_read");
        end
    endtask

    // Write to addr 25, reset after `when` cycles (WAIT or RESP), re-finish
    // boot without reloading, and expect the old word back.
    task automatic test_reset_mid_access(input int i, input int when);
        logic [15:0] d;
        d = (exp_mem[i][25] == 16'hAAAA) ? 16'h5555 : 16'hAAAA;
        mem_req[i] = 1'b1; write_enable[i] = 1'b1; ram_addr[i] = 5'd25; data_out[i] = d;
        tick;
        mem_req[i] = 1'b0;
        for (int k = 1; k < when; k++) tick;
        rst[i] = 1'b1;
        tick;
        rst[i] = 1'b0;
        exp_dout[i] = 16'h0000;
        n_cmp++;
        if (boot_done[i] !== 1'b0 || mem_ack[i] !== 1'b0 || data_in[i] !== 16'h0000) begin
            n_bad++;
            $display("FAIL midreset inst%0d cycle %0d: boot_done=%b mem_ack=%b data_in=%h, expected 0 0 0000",
                     i, when, boot_done[i], mem_ack[i], data_in[i]);
        end
        load_done[i] = 1'b1;
        tick;
        load_done[i] = 1'b0;
        n_cmp++;
        if (boot_done[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset inst%0d reboot: boot_done=%b, expected 1", i, boot_done[i]);
        end
        access(i, 1'b0, 5'd25, 16'h0, "midreset_read25");
    endtask

    initial begin
        for (int i = 0; i < N; i++) idle_inputs(i);
        rst = '1;
        test_reset();
        for (int i = 0; i < N; i++) test_boot(i);
        test_latency();
        test_protect();
        test_write_read();
        for (int i = 0; i < N; i++) test_ignored(i);
        for (int i = 0; i < N; i++) test_back_to_back(i);
        for (int i = 0; i < N; i++) test_random(i);
        for (int i = 0; i < N; i++) begin
            test_reset_mid_access(i, 1);
            test_reset_mid_access(i, wc_of(i) + 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
